uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one UART `transmitter` between `NREQ` byte-stream requesters. It accepts one byte at a time over a valid/ready handshake and issues a single-cycle `tx_start` with stable `tx_din`. It then waits for `tx_done_tick` before granting again. It sits between client logic (command responders, loggers, debug ports) and the transmitter's `tx_start`/`tx_din`/`tx_done_tick` pins.

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter between NREQ byte
//            requesters; optional per-packet locking via UART_TX_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DBIT = 8,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [DBIT-1:0] din_q, din_d;
  logic [NREQ-1:0] elig;
  logic [GW-1:0]   win_idx;
  logic            win_found;
  logic            accept;

`ifdef UART_TX_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [GW-1:0] owner_q, owner_d;

  // While a packet is open only its owner may be granted, valid or not.
  always_comb begin
    elig = req_valid;
    if (lock_q) elig = req_valid & (NREQ'(1) << owner_q);
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (accept) begin
      lock_d  = ~req_last[win_idx];
      owner_d = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig        = req_valid;
`endif

  // Walk upward from ptr with an explicit wrap so any NREQ works.
  always_comb begin
    int cand;
    logic [GW-1:0] idx;
    cand      = 0;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      idx = cand[GW-1:0];
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && win_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (tx_done_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    din_d   = din_q;
    if (accept) begin
      din_d   = req_data[win_idx*DBIT +: DBIT];
      grant_d = win_idx;
      ptr_d   = (win_idx == GW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
    tx_start = (state_q == S_START);
    busy     = (state_q != S_IDLE);
  end

  assign tx_din   = din_q;
  assign grant_id = grant_q;

endmodule

`default_nettype wire
